// File: rtl/updown_sweep_ctrl.sv
// Triangular sweep sequencer: ramps count lo->hi, dwells at hi, ramps back to lo,
// repeating a programmed number of sweeps or continuously until aborted.
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int CWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [3:0]        hold,
  input  logic [CWIDTH-1:0] cycles,
  output logic [WIDTH-1:0]  count,
  output logic              up_down,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CWIDTH-1:0] sweep_cnt
);

  typedef enum logic [2:0] {IDLE, UP, HOLD, DOWN, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  lo_q, hi_q, lo_n, hi_n, count_n;
  logic [3:0]        hold_q, hold_n, dwell, dwell_n;
  logic [CWIDTH-1:0] cyc_q, cyc_n, sc_n, sc_inc;
  logic              ud_n, err_n;

  assign sc_inc = sweep_cnt + CWIDTH'(1);
  assign busy   = (state == UP) || (state == HOLD) || (state == DOWN);
  assign done   = (state == DONE);

  always_comb begin
    state_n = state;
    lo_n    = lo_q;
    hi_n    = hi_q;
    hold_n  = hold_q;
    cyc_n   = cyc_q;
    dwell_n = dwell;
    count_n = count;
    ud_n    = up_down;
    err_n   = err;
    sc_n    = sweep_cnt;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          lo_n   = lo;
          hi_n   = hi;
          hold_n = hold;
          cyc_n  = cycles;
          sc_n   = '0;
          err_n  = 1'b0;
          if (lo < hi) begin
            count_n = lo;
            ud_n    = 1'b1;
            state_n = UP;
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      UP: begin
        if (abort) state_n = IDLE;
        else begin
          // lo < hi was checked at start, so count < hi here and cannot overflow
          count_n = count + WIDTH'(1);
          if (count == hi_q - WIDTH'(1)) begin
            if (hold_q != 4'd0) begin
              state_n = HOLD;
              dwell_n = hold_q;
            end else begin
              state_n = DOWN;
              ud_n    = 1'b0;
            end
          end
        end
      end
      HOLD: begin
        if (abort) state_n = IDLE;
        else begin
          dwell_n = dwell - 4'd1;
          if (dwell == 4'd1) begin
            state_n = DOWN;
            ud_n    = 1'b0;
          end
        end
      end
      DOWN: begin
        if (abort) state_n = IDLE;
        else begin
          count_n = count - WIDTH'(1);
          if (count == lo_q + WIDTH'(1)) begin
            sc_n = sc_inc;
            if (cyc_q != '0 && sc_inc == cyc_q) state_n = DONE;
            else begin
              state_n = UP;
              ud_n    = 1'b1;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      hold_q    <= '0;
      cyc_q     <= '0;
      dwell     <= '0;
      count     <= '0;
      up_down   <= 1'b1;
      err       <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      state     <= state_n;
      lo_q      <= lo_n;
      hi_q      <= hi_n;
      hold_q    <= hold_n;
      cyc_q     <= cyc_n;
      dwell     <= dwell_n;
      count     <= count_n;
      up_down   <= ud_n;
      err       <= err_n;
      sweep_cnt <= sc_n;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: expected waveforms are built as a per-cycle list
// from the sweep shape (ramp up, dwell, ramp down) and compared after each edge.
module tb_updown_sweep_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  lo = '0, hi = '0;
  logic [3:0]    hold = '0;
  logic [CW-1:0] cycles = '0;
  logic [W-1:0]  count;
  logic          up_down, busy, done, err;
  logic [CW-1:0] sweep_cnt;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_cnt;

  typedef struct {
    logic [W-1:0]  cnt;
    logic          ud;
    logic          bsy;
    logic          dn;
    logic [CW-1:0] sc;
    logic          down;
  } exp_t;
  exp_t q[$];

  updown_sweep_ctrl #(.WIDTH(W), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .hold(hold), .cycles(cycles),
    .count(count), .up_down(up_down), .busy(busy), .done(done),
    .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  function automatic void push_e(int c, bit u, bit b, bit d, int s, bit dw);
    exp_t e;
    e.cnt = W'(c); e.ud = u; e.bsy = b; e.dn = d; e.sc = CW'(s); e.down = dw;
    q.push_back(e);
  endfunction

  // One entry per clock after the accepting edge; n=0 means no final done.
  function automatic void build(int l, int h, int hd, int n, int nsw);
    bit last;
    q.delete();
    push_e(l, 1, 1, 0, 0, 0);
    for (int s = 0; s < nsw; s++) begin
      for (int v = l + 1; v < h; v++) push_e(v, 1, 1, 0, s, 0);
      for (int k = 0; k <= hd; k++) push_e(h, k != hd, 1, 0, s, 0);
      for (int v = h - 1; v > l; v--) push_e(v, 0, 1, 0, s, 1);
      last = (n != 0) && (s == nsw - 1);
      push_e(l, !last, !last, last, (s + 1) % 256, 1);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; lo = 4'd3; hi = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (count !== 4'd0 || up_down !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: count=%0d ud=%b busy=%b done=%b err=%b sc=%0d, need 0 1 0 0 0 0",
               count, up_down, busy, done, err, sweep_cnt);
    end
    start = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || count !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b count=%0d done=%b, need 0 0 0", busy, count, done);
    end
    last_cnt = '0;
  endtask

  // Runs one programmed sweep job; with noise, start and config inputs toggle while busy.
  task automatic test_sweep(string name, int l, int h, int hd, int n, bit noise);
    lo = W'(l); hi = W'(h); hold = 4'(hd); cycles = CW'(n); start = 1'b1;
    build(l, h, hd, n, n);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (count !== q[i].cnt || up_down !== q[i].ud) begin
        errors++;
        $display("FAIL %s step %0d: count=%0d ud=%b, need %0d %b",
                 name, i, count, up_down, q[i].cnt, q[i].ud);
      end
      checks++;
      if (busy !== q[i].bsy || done !== q[i].dn || sweep_cnt !== q[i].sc || err !== 1'b0) begin
        errors++;
        $display("FAIL %s_status step %0d: busy=%b done=%b sc=%0d err=%b, need %b %b %0d 0",
                 name, i, busy, done, sweep_cnt, err, q[i].bsy, q[i].dn, q[i].sc);
      end
      if (noise) begin
        lo = W'($urandom); hi = W'($urandom); hold = 4'($urandom); cycles = CW'($urandom);
        start = 1'($urandom);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== W'(l) || sweep_cnt !== CW'(n)) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b count=%0d sc=%0d, need 0 0 %0d %0d",
               name, busy, done, count, sweep_cnt, l, n);
    end
    last_cnt = W'(l);
  endtask

  task automatic test_continuous();
    int hd;
    int i;
    bit hit;
    hd = $urandom_range(0, 3);
    lo = 4'd0; hi = 4'd15; hold = 4'(hd); cycles = 8'd0; start = 1'b1;
    build(0, 15, hd, 0, 3);
    hit = 1'b0;
    i = 0;
    while (i < q.size() && !hit) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (count !== q[i].cnt || up_down !== q[i].ud || busy !== 1'b1 ||
          done !== 1'b0 || sweep_cnt !== q[i].sc) begin
        errors++;
        $display("FAIL continuous step %0d: count=%0d ud=%b busy=%b done=%b sc=%0d, need %0d %b 1 0 %0d",
                 i, count, up_down, busy, done, sweep_cnt, q[i].cnt, q[i].ud, q[i].sc);
      end
      if (q[i].down && q[i].sc == 8'd2 && q[i].cnt == 4'd9) begin
        abort = 1'b1;
        hit = 1'b1;
      end
      i++;
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      abort = 1'b0;
      checks++;
      if (!hit || count !== 4'd9 || up_down !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || sweep_cnt !== 8'd2) begin
        errors++;
        $display("FAIL abort cyc %0d: count=%0d ud=%b busy=%b done=%b sc=%0d, need 9 0 0 0 2",
                 k, count, up_down, busy, done, sweep_cnt);
      end
    end
    last_cnt = 4'd9;
  endtask

  task automatic test_config_err(int l, int h);
    lo = W'(l); hi = W'(h); hold = 4'd1; cycles = 8'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== last_cnt || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL cfg_err %0d/%0d: err=%b done=%b busy=%b count=%0d sc=%0d, need 1 1 0 %0d 0",
               l, h, err, done, busy, count, sweep_cnt, last_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || count !== last_cnt) begin
      errors++;
      $display("FAIL cfg_err_after %0d/%0d: err=%b done=%b busy=%b count=%0d, need 1 0 0 %0d",
               l, h, err, done, busy, count, last_cnt);
    end
  endtask

  task automatic test_collisions();
    lo = 4'd1; hi = 4'd8; start = 1'b1; abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== last_cnt) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b done=%b count=%0d, need 0 0 %0d",
               busy, done, count, last_cnt);
    end
    lo = 4'd2; hi = 4'd5; hold = 4'd3; cycles = 8'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_hold: count=%0d busy=%b, need 5 1", count, busy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (count !== 4'd0 || up_down !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_in_hold: count=%0d ud=%b busy=%b done=%b err=%b sc=%0d, need 0 1 0 0 0 0",
               count, up_down, busy, done, err, sweep_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_hold_after: busy=%b done=%b, need 0 0", busy, done);
    end
    last_cnt = '0;
  endtask

  task automatic test_random();
    int l, h;
    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(0, 14);
      h = $urandom_range(l + 1, 15);
      test_sweep("random", l, h, $urandom_range(0, 15), $urandom_range(1, 3), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("basic", 2, 5, 0, 1, 1'b0);
    test_sweep("hold", 2, 5, 2, 2, 1'b0);
    test_sweep("full_range", 0, 15, 1, 1, 1'b0);
    test_sweep("narrow", 14, 15, 0, 2, 1'b0);
    test_continuous();
    test_config_err(7, 7);
    test_config_err(9, 3);
    test_sweep("err_clear", 1, 6, 1, 1, 1'b0);
    test_sweep("mid_start", 3, 10, 2, 2, 1'b1);
    test_collisions();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
